frg_stim_sig_engine: RTL and testbench

- Sequential stimulus/response engine for the combinational frg-class benchmarks (28 inputs, 3 outputs): the driving and observing end of a benchmark's port interface.
- Generates pseudo-random input vectors with an LFSR, drives them into the combinational netlist, and compacts the returned outputs into a MISR signature.
- Used to compare a golden netlist against a resynthesised or DD-rebuilt netlist on-chip or in simulation by signature equality.

---
 rtl/frg_bench_pkg.sv | 21 ++
 rtl/frg_misr.sv | 39 +++
 rtl/frg_stim_sig_engine.sv | 126 ++++++++++++
 tb/tb_frg_stim_sig_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/frg_bench_pkg.sv
// Shared types and constants for the frg stimulus/signature engine.
// Holds the FSM state enum, default widths and the LFSR/MISR polynomials.
package frg_bench_pkg;

  localparam int IN_W_DEF  = 28;
  localparam int OUT_W_DEF = 3;
  localparam int SIG_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  // x^28 + x^25 + 1, Galois right-shift form
  localparam logic [27:0] LFSR_TAPS_28 = 28'h9000000;
  localparam logic [15:0] MISR_POLY_16 = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/frg_misr.sv
// Galois right-shift MISR that compacts netlist responses into a signature.
// Clear has priority over enable; response bits land in the low bits.
module frg_misr
  import frg_bench_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter int               OUT_W = OUT_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY_16)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] shifted;

  // shift with feedback, then inject the response
  always_comb begin
    shifted = {1'b0, sig_q[SIG_W-1:1]};
    if (sig_q[0]) shifted = shifted ^ POLY;
    sig_d = sig_q;
    if (clr_i)     sig_d = '0;
    else if (en_i) sig_d = shifted ^ SIG_W'(din_i);
  end

  // signature register
  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/frg_stim_sig_engine.sv
// LFSR stimulus generator and MISR response compactor for frg benchmarks.
// Define FRG_STIM_STALL_EN to add a stall input that freezes RUN cycles.
module frg_stim_sig_engine
  import frg_bench_pkg::*;
#(
  parameter int               IN_W      = IN_W_DEF,
  parameter int               OUT_W     = OUT_W_DEF,
  parameter int               SIG_W     = SIG_W_DEF,
  parameter int               CNT_W     = CNT_W_DEF,
  parameter logic [IN_W-1:0]  LFSR_TAPS = IN_W'(LFSR_TAPS_28),
  parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(MISR_POLY_16)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_vec,
`ifdef FRG_STIM_STALL_EN
  input  logic             stall,
`endif
  output logic [IN_W-1:0]  vec_out,
  output logic             vec_valid,
  input  logic [OUT_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [IN_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [IN_W-1:0]  lfsr_nx;
  logic             stall_w;
  logic             accept;
  logic             adv;
  logic             last;

`ifdef FRG_STIM_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign accept = (state_q == IDLE) && start;
  assign adv    = (state_q == RUN) && !stall_w;
  assign last   = (cnt_q == num_q - CNT_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = (num_q == '0) ? DONE : RUN;
      RUN:  if (adv && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state; vec_out holds the last applied vector
  always_comb begin
    busy      = (state_q == LOAD) || (state_q == RUN);
    done      = (state_q == DONE);
    vec_valid = adv;
    vec_out   = (state_q == RUN) ? lfsr_q : hold_q;
  end

  // datapath next values: seed load on accept, advance on applied vectors
  always_comb begin
    lfsr_nx = {1'b0, lfsr_q[IN_W-1:1]};
    if (lfsr_q[0]) lfsr_nx = lfsr_nx ^ LFSR_TAPS;
    lfsr_d = lfsr_q;
    hold_d = hold_q;
    cnt_d  = cnt_q;
    num_d  = num_q;
    if (accept) begin
      lfsr_d = (seed == '0) ? IN_W'(1) : seed;
      cnt_d  = '0;
      num_d  = num_vec;
    end else if (adv) begin
      lfsr_d = lfsr_nx;
      hold_d = lfsr_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
    end
  end

  frg_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (adv),
    .din_i (resp_in),
    .sig_o (signature)
  );

  assign vec_count = cnt_q;

endmodule

// File: tb/tb_frg_stim_sig_engine.sv
// Scoreboard bench for frg_stim_sig_engine: expected vectors and run results
// are queued by stimulus and consumed by a negedge monitor.
module tb_frg_stim_sig_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [27:0] seed;
  logic [15:0] num_vec;
  logic        stall;
  logic [27:0] vec_out;
  logic        vec_valid;
  logic [2:0]  resp_in;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] vec_count;

  typedef struct {
    logic [15:0] sig;
    logic [15:0] cnt;
    int          cyc;
  } dexp_t;

  logic [27:0] vq[$];
  dexp_t       dq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_done = 1'b0;
  logic [27:0] ev;
  dexp_t       ed;

  frg_stim_sig_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .num_vec   (num_vec),
`ifdef FRG_STIM_STALL_EN
    .stall     (stall),
`endif
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pop and compare whenever the DUT presents a vector or done
  always @(negedge clk) begin
    if (!rst) begin
      if (vec_valid) begin
        if (vq.size() == 0) chk("unexpected_vec", vec_valid, 0);
        else begin
          ev = vq.pop_front();
          chk("vec_out", vec_out, ev);
        end
      end
      if (done) begin
        chk("done_width", prev_done, 0);
        if (dq.size() == 0) chk("unexpected_done", done, 0);
        else begin
          ed = dq.pop_front();
          chk("signature", signature, ed.sig);
          chk("vec_count", vec_count, ed.cnt);
          chk("done_cycle", cyc, ed.cyc);
          chk("busy_at_done", busy, 0);
        end
      end
    end
    prev_done = done;
  end

  // called just after a posedge; start is accepted at the next edge
  task automatic run(input logic [27:0] s, input logic [15:0] n,
                     input logic [2:0] r, input logic [15:0] sig,
                     input int stalls);
    dexp_t d;
    seed    = s;
    num_vec = n;
    resp_in = r;
    d.sig   = sig;
    d.cnt   = n;
    d.cyc   = cyc + int'(n) + 2 + stalls;
    dq.push_back(d);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 300 && dq.size() != 0; i++) @(posedge clk);
    chk("done_seen", dq.size(), 0);
    dq.delete();
    @(posedge clk);
    #1;
    chk("sig_hold", signature, sig);
    chk("cnt_hold", vec_count, n);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, vec_valid, 0);
    chk({tag, "_vec"}, vec_out, 0);
    chk({tag, "_sig"}, signature, 0);
    chk({tag, "_cnt"}, vec_count, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    seed    = '0;
    num_vec = '0;
    stall   = 1'b0;
    resp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    vq.push_back(28'h0000001);
    run(28'h0000001, 16'd1, 3'b101, 16'h0005, 0);

    vq.push_back(28'h0000001);
    vq.push_back(28'h9000000);
    run(28'h0000001, 16'd2, 3'b101, 16'hB407, 0);
    chk("vec_out_hold", vec_out, 28'h9000000);

    run(28'h1234567, 16'd0, 3'b111, 16'h0000, 0);
    chk("vec_out_hold_n0", vec_out, 28'h9000000);

    vq.push_back(28'h0000001);
    run(28'h0000000, 16'd1, 3'b101, 16'h0005, 0);

    vq.push_back(28'h0000003);
    vq.push_back(28'h9000001);
    vq.push_back(28'hD800000);
    vq.push_back(28'h6C00000);
    run(28'h0000003, 16'd4, 3'b110, 16'h5A04, 0);

    vq.push_back(28'h0000003);
    vq.push_back(28'h9000001);
    vq.push_back(28'hD800000);
    seed    = 28'h0000003;
    num_vec = 16'd10;
    resp_in = 3'b110;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    seed = 28'h0000001;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vq.delete();
    chk_zero("abort");
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 0);

    vq.push_back(28'h0000001);
    vq.push_back(28'h9000000);
    run(28'h0000001, 16'd2, 3'b101, 16'hB407, 0);

`ifdef FRG_STIM_STALL_EN
    vq.push_back(28'h0000001);
    vq.push_back(28'h9000000);
    fork
      run(28'h0000001, 16'd2, 3'b101, 16'hB407, 1);
      begin
        repeat (3) @(posedge clk);
        #1 stall = 1'b1;
        @(posedge clk);
        #1 stall = 1'b0;
      end
    join
`endif

    chk("vq_empty", vq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
